// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and writeback source encoding
package regfile_pkg;
  localparam int XLEN  = 64;
  localparam int NREG  = 32;
  localparam int IDX_W = 5;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} wb_src_e;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// rtl/regfile_wb_ctrl_if.sv - writeback request, issue/check and regfile write bundle
interface regfile_wb_ctrl_if #(parameter int XLEN = regfile_pkg::XLEN);
  import regfile_pkg::*;

  logic             alu_valid;
  logic [IDX_W-1:0] alu_idx;
  logic [XLEN-1:0]  alu_data;
  logic             alu_ready;
  logic             mem_valid;
  logic [IDX_W-1:0] mem_idx;
  logic [XLEN-1:0]  mem_data;
  logic             mem_ready;
  logic             iss_en;
  logic [IDX_W-1:0] iss_idx;
  logic [IDX_W-1:0] chk1_idx;
  logic [IDX_W-1:0] chk2_idx;
  logic             hazard;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [XLEN-1:0]  wr_data;

  modport master (
    output alu_valid, alu_idx, alu_data, mem_valid, mem_idx, mem_data,
    output iss_en, iss_idx, chk1_idx, chk2_idx,
    input  alu_ready, mem_ready, hazard, wr_en, wr_idx, wr_data
  );

  modport slave (
    input  alu_valid, alu_idx, alu_data, mem_valid, mem_idx, mem_data,
    input  iss_en, iss_idx, chk1_idx, chk2_idx,
    output alu_ready, mem_ready, hazard, wr_en, wr_idx, wr_data
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with combinational one-hot grant
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  wb_src_e last_grant;

  // bit 0 is the ALU, bit 1 the load unit; a grant is also the transfer
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == SRC_MEM) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= SRC_MEM;
    end else if (gnt[0]) begin
      last_grant <= SRC_ALU;
    end else if (gnt[1]) begin
      last_grant <= SRC_MEM;
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - writeback arbitration, registered regfile write and pending scoreboard
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int NREG = regfile_pkg::NREG
) (
  input  logic             clk,
  input  logic             reset,
  regfile_wb_ctrl_if.slave bus
);
  logic [1:0]       gnt;
  logic [IDX_W-1:0] sel_idx;
  logic [XLEN-1:0]  sel_data;
  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_nxt;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.mem_valid, bus.alu_valid}),
    .gnt   (gnt)
  );

  assign bus.alu_ready = gnt[0];
  assign bus.mem_ready = gnt[1];

  always_comb begin
    sel_idx  = gnt[1] ? bus.mem_idx  : bus.alu_idx;
    sel_data = gnt[1] ? bus.mem_data : bus.alu_data;
  end

  // clear first so an issue to the same index at the same edge keeps it pending
  always_comb begin
    pending_nxt = pending;
    if (bus.wr_en) pending_nxt[bus.wr_idx] = 1'b0;
    if (bus.iss_en && bus.iss_idx != '0) pending_nxt[bus.iss_idx] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  assign bus.hazard = pending[bus.chk1_idx] | pending[bus.chk2_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_idx  <= '0;
      bus.wr_data <= '0;
    end else begin
      pending <= pending_nxt;
      if (|gnt) begin
        // x0 writes are accepted but never reach the register file
        bus.wr_en   <= (sel_idx != '0);
        bus.wr_idx  <= sel_idx;
        bus.wr_data <= sel_data;
      end else begin
        bus.wr_en <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - directed and randomized bench with a behavioural writeback model
module tb_regfile_wb_ctrl;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if #(.XLEN(64)) bus ();

  regfile_wb_ctrl #(.XLEN(64), .NREG(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  bit [31:0]   m_pend;
  int          m_last;   // 0: ALU granted most recently, 1: MEM
  bit          m_wen;
  logic [4:0]  m_widx;
  logic [63:0] m_wdata;
  bit          g_alu, g_mem;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_idx = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_idx = '0; bus.mem_data = '0;
    bus.iss_en = 1'b0; bus.iss_idx = '0;
    bus.chk1_idx = '0; bus.chk2_idx = '0;
  endtask

  // one clock cycle: check all outputs against the model, then advance the model
  task automatic tick();
    bit ea, em, eh;
    #1;
    ea = !reset && bus.alu_valid && (!bus.mem_valid || m_last == 1);
    em = !reset && bus.mem_valid && (!bus.alu_valid || m_last == 0);
    eh = m_pend[bus.chk1_idx] | m_pend[bus.chk2_idx];
    check("alu_ready", bus.alu_ready, ea);
    check("mem_ready", bus.mem_ready, em);
    check("hazard", bus.hazard, eh);
    check("wr_en", bus.wr_en, m_wen);
    if (m_wen) begin
      check("wr_idx", bus.wr_idx, m_widx);
      check("wr_data", bus.wr_data, m_wdata);
    end
    g_alu = ea;
    g_mem = em;
    if (reset) begin
      m_pend = '0; m_last = 1; m_wen = 0; m_widx = '0; m_wdata = '0;
    end else begin
      if (m_wen) m_pend[m_widx] = 1'b0;
      if (bus.iss_en && bus.iss_idx != 0) m_pend[bus.iss_idx] = 1'b1;
      if (ea) begin
        m_wen = (bus.alu_idx != 0); m_widx = bus.alu_idx; m_wdata = bus.alu_data; m_last = 0;
      end else if (em) begin
        m_wen = (bus.mem_idx != 0); m_widx = bus.mem_idx; m_wdata = bus.mem_data; m_last = 1;
      end else begin
        m_wen = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.alu_valid = 1'b1; bus.mem_valid = 1'b1;
    tick();
    idle();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_gnt_idx [4];
    reset = 1'b1;
    idle();
    m_pend = '0; m_last = 1; m_wen = 0; m_widx = '0; m_wdata = '0;
    @(negedge clk);
    do_reset();

    // reset state
    #1;
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_wr_idx", bus.wr_idx, 5'd0);
    check("rst_wr_data", bus.wr_data, 64'd0);
    check("rst_hazard", bus.hazard, 1'b0);

    // single ALU writeback
    bus.alu_valid = 1'b1; bus.alu_idx = 5'd5; bus.alu_data = 64'hAA;
    #1 check("t28_alu_ready", bus.alu_ready, 1'b1);
    tick();
    idle();
    #1;
    check("t28_wr_en", bus.wr_en, 1'b1);
    check("t28_wr_idx", bus.wr_idx, 5'd5);
    check("t28_wr_data", bus.wr_data, 64'hAA);
    tick();

    // sustained contention alternates, ALU first after reset
    do_reset();
    exp_gnt_idx = '{5'd3, 5'd4, 5'd3, 5'd4};
    bus.alu_valid = 1'b1; bus.alu_idx = 5'd3; bus.alu_data = 64'h33;
    bus.mem_valid = 1'b1; bus.mem_idx = 5'd4; bus.mem_data = 64'h44;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t29_alu_gnt", bus.alu_ready, exp_gnt_idx[i] == 5'd3);
      check("t29_mem_gnt", bus.mem_ready, exp_gnt_idx[i] == 5'd4);
      if (i > 0) check("t29_wr_order", bus.wr_idx, exp_gnt_idx[i-1]);
      tick();
    end
    idle();
    #1 check("t29_wr_last", bus.wr_idx, 5'd4);
    tick();

    // load to x0 is accepted but not written
    bus.mem_valid = 1'b1; bus.mem_idx = 5'd0; bus.mem_data = 64'hFF;
    #1 check("t30_mem_ready", bus.mem_ready, 1'b1);
    tick();
    idle();
    #1 check("t30_wr_en", bus.wr_en, 1'b0);
    tick();

    // hazard lifetime on x7
    bus.iss_en = 1'b1; bus.iss_idx = 5'd7;
    tick();
    idle();
    bus.chk1_idx = 5'd7;
    bus.alu_valid = 1'b1; bus.alu_idx = 5'd7; bus.alu_data = 64'h77;
    #1 check("t31_hazard_set", bus.hazard, 1'b1);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    check("t31_wr_en", bus.wr_en, 1'b1);
    check("t31_hazard_wr", bus.hazard, 1'b1);
    tick();
    #1 check("t31_hazard_clr", bus.hazard, 1'b0);
    tick();

    // issue collides with the write clearing the same index
    bus.iss_en = 1'b1; bus.iss_idx = 5'd9;
    tick();
    idle();
    bus.alu_valid = 1'b1; bus.alu_idx = 5'd9; bus.alu_data = 64'h99;
    tick();
    idle();
    bus.iss_en = 1'b1; bus.iss_idx = 5'd9;
    #1 check("t32_wr_en", bus.wr_en, 1'b1);
    tick();
    idle();
    bus.chk2_idx = 5'd9;
    #1 check("t32_hazard", bus.hazard, 1'b1);
    tick();

    // reset right after a transfer drops the pending write
    bus.alu_valid = 1'b1; bus.alu_idx = 5'd12; bus.alu_data = 64'h1212;
    bus.iss_en = 1'b1; bus.iss_idx = 5'd20;
    tick();
    idle();
    reset = 1'b1;
    bus.alu_valid = 1'b1; bus.mem_valid = 1'b1;
    #1;
    check("t33_ready_alu", bus.alu_ready, 1'b0);
    check("t33_ready_mem", bus.mem_ready, 1'b0);
    tick();
    #1;
    check("t33_wr_en", bus.wr_en, 1'b0);
    check("t33_ready_alu2", bus.alu_ready, 1'b0);
    tick();
    reset = 1'b0;
    idle();
    for (int r = 0; r < 32; r++) begin
      bus.chk1_idx = 5'(r); bus.chk2_idx = 5'(r);
      #1 check("t33_pending_clr", bus.hazard, 1'b0);
    end
    tick();

    // randomized traffic, requesters hold while not granted
    for (int c = 0; c < 400; c++) begin
      if (!(bus.alu_valid && !g_alu)) begin
        bus.alu_valid = ($urandom_range(0, 2) != 0);
        bus.alu_idx   = 5'($urandom_range(0, 31));
        bus.alu_data  = {$urandom, $urandom};
      end
      if (!(bus.mem_valid && !g_mem)) begin
        bus.mem_valid = ($urandom_range(0, 2) != 0);
        bus.mem_idx   = 5'($urandom_range(0, 31));
        bus.mem_data  = {$urandom, $urandom};
      end
      bus.iss_en   = ($urandom_range(0, 1) != 0);
      bus.iss_idx  = 5'($urandom_range(0, 31));
      bus.chk1_idx = 5'($urandom_range(0, 31));
      bus.chk2_idx = 5'($urandom_range(0, 31));
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
